// File: rtl/pmem_burst_ctrl.sv
// Cache-line to memory-burst sequencer: latches one arbiter line request, runs a
// BEATS-beat read or write burst on the narrow bus, and answers with a one-cycle line_resp.
module pmem_burst_ctrl #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] line_address,
  input  logic [LINE_W-1:0] line_wdata,
  input  logic              line_read,
  input  logic              line_write,
  output logic              line_resp,
  output logic [LINE_W-1:0] line_rdata,
  output logic [ADDR_W-1:0] burst_address,
  output logic [BEAT_W-1:0] burst_wdata,
  output logic              burst_read,
  output logic              burst_write,
  input  logic              burst_resp,
  input  logic [BEAT_W-1:0] burst_rdata
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] asm_q, asm_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              last_beat;

  // Byte offset within the line is dropped when the address is latched.
  logic unused_addr_bits;
  assign unused_addr_bits = ^line_address[OFF_W-1:0];

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    rdata_d    = rdata_q;
    last_beat  = (beat_cnt_q == CNT_W'(BEATS - 1));
    case (state_q)
      IDLE: begin
        if (line_write || line_read) begin
          addr_d     = {line_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          wdata_d    = line_wdata;
          beat_cnt_d = '0;
          state_d    = line_write ? WR_BURST : RD_BURST;
        end
      end
      RD_BURST: begin
        if (burst_resp) begin
          asm_d[beat_cnt_q*BEAT_W +: BEAT_W] = burst_rdata;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (last_beat) begin
            // Publish the whole line only once it is complete.
            rdata_d = asm_d;
            state_d = DONE;
          end
        end
      end
      WR_BURST: begin
        if (burst_resp) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (last_beat) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      asm_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      asm_q      <= asm_d;
      rdata_q    <= rdata_d;
    end
  end

  assign line_resp     = (state_q == DONE);
  assign burst_read    = (state_q == RD_BURST);
  assign burst_write   = (state_q == WR_BURST);
  assign burst_address = addr_q;
  assign burst_wdata   = wdata_q[beat_cnt_q*BEAT_W +: BEAT_W];
  assign line_rdata    = rdata_q;

endmodule

// File: tb/tb_pmem_burst_ctrl.sv
// Bench for pmem_burst_ctrl: a memory responder model serves bursts from a line-indexed
// memory, and a scoreboard checks every line_resp against the expected line.
module tb_pmem_burst_ctrl;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = LINE_W / BEAT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] line_address = '0;
  logic [LINE_W-1:0] line_wdata = '0;
  logic              line_read = 1'b0;
  logic              line_write = 1'b0;
  logic              line_resp;
  logic [LINE_W-1:0] line_rdata;
  logic [ADDR_W-1:0] burst_address;
  logic [BEAT_W-1:0] burst_wdata;
  logic              burst_read;
  logic              burst_write;
  logic              burst_resp = 1'b0;
  logic [BEAT_W-1:0] burst_rdata = '0;

  always #5 clk = ~clk;

  pmem_burst_ctrl #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .rst(rst),
    .line_address(line_address), .line_wdata(line_wdata),
    .line_read(line_read), .line_write(line_write),
    .line_resp(line_resp), .line_rdata(line_rdata),
    .burst_address(burst_address), .burst_wdata(burst_wdata),
    .burst_read(burst_read), .burst_write(burst_write),
    .burst_resp(burst_resp), .burst_rdata(burst_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: memory contents by aligned line address, last completed read.
  logic [LINE_W-1:0] mem [logic [31:0]];
  logic [LINE_W-1:0] sb_q [$];
  logic [LINE_W-1:0] last_read = '0;
  logic [LINE_W-1:0] cur_line = '0;
  logic [LINE_W-1:0] cur_wdata = '0;
  logic [31:0]       cur_addr = '0;
  logic              cur_is_write = 1'b0;
  logic [LINE_W-1:0] mon_exp;

  // Responder knobs: 0 random acks, 1 ack every cycle, 2 two idle cycles between beats,
  // 3 ack only the first resp_limit beats. stray_mode: 0 none, 1 random, 2 always.
  int resp_mode  = 1;
  int stray_mode = 0;
  int resp_limit = BEATS;
  bit abort_ok   = 1'b0;
  int beat_k     = 0;
  int gap_cnt    = 0;
  bit active_prev = 1'b0;
  bit give;

  task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                             input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: event not satisfied", name);
  endtask

  function automatic logic [LINE_W-1:0] randLine();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Memory side: acknowledges beats, serves read data, checks write beats in order.
  always @(negedge clk) begin
    if (rst) begin
      beat_k      = 0;
      gap_cnt     = 0;
      active_prev = 1'b0;
      burst_resp  = 1'b0;
    end else if (burst_read || burst_write) begin
      checkOutput("burst_kind", 256'({burst_write, burst_read}),
                  cur_is_write ? 256'(2'b10) : 256'(2'b01));
      checkOutput("burst_address", 256'(burst_address), 256'(cur_addr));
      give = 1'b0;
      if (beat_k >= BEATS) failNow("burst_overrun");
      else begin
        case (resp_mode)
          0: give = ($urandom_range(0, 1) == 1);
          1: give = 1'b1;
          2: begin
            if (gap_cnt == 0) begin
              give    = 1'b1;
              gap_cnt = 2;
            end else gap_cnt--;
          end
          default: give = (beat_k < resp_limit);
        endcase
      end
      burst_resp  = give;
      burst_rdata = {$urandom, $urandom};
      if (give) begin
        if (burst_read) burst_rdata = cur_line[beat_k*BEAT_W +: BEAT_W];
        else checkOutput("burst_wdata", 256'(burst_wdata),
                         256'(cur_wdata[beat_k*BEAT_W +: BEAT_W]));
        beat_k++;
      end
      active_prev = 1'b1;
    end else begin
      if (active_prev && beat_k != BEATS && !abort_ok) failNow("burst_dropped_early");
      beat_k      = 0;
      gap_cnt     = 0;
      active_prev = 1'b0;
      burst_resp  = (stray_mode == 2) || (stray_mode == 1 && $urandom_range(0, 3) == 0);
      burst_rdata = {$urandom, $urandom};
    end
  end

  // Scoreboard monitor: every line_resp consumes exactly one expected line.
  always @(negedge clk) begin
    if (!rst && line_resp) begin
      checkOutput("resp_burst_low", 256'({burst_read, burst_write}), 256'(0));
      if (sb_q.size() == 0) failNow("unexpected_line_resp");
      else begin
        mon_exp = sb_q.pop_front();
        checkOutput("line_rdata", line_rdata, mon_exp);
      end
    end
  end

  // Issues one line request (called at a negedge) and holds it until line_resp.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [LINE_W-1:0] wdata, input int exp_lat);
    logic [31:0] aligned;
    int lat;
    bit done;
    aligned      = addr & 32'hFFFF_FFE0;
    cur_addr     = aligned;
    cur_is_write = wr;
    if (wr) begin
      mem[aligned] = wdata;
      cur_wdata    = wdata;
      sb_q.push_back(last_read);
    end else begin
      if (!mem.exists(aligned)) mem[aligned] = randLine();
      cur_line  = mem[aligned];
      last_read = cur_line;
      sb_q.push_back(cur_line);
    end
    line_address = addr;
    line_wdata   = wdata;
    line_read    = rd;
    line_write   = wr;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (line_resp) done = 1'b1;
      else if (burst_read || burst_write) begin
        line_address = $urandom;
        line_wdata   = randLine();
      end
    end
    line_read  = 1'b0;
    line_write = 1'b0;
    if (!done) failNow("line_resp_timeout");
    else if (exp_lat > 0) checkOutput("latency", 256'(lat), 256'(exp_lat));
  endtask

  initial begin
    logic [LINE_W-1:0] tmp;
    repeat (3) @(negedge clk);
    checkOutput("reset_line_resp", 256'(line_resp), 256'(0));
    checkOutput("reset_burst_rw", 256'({burst_read, burst_write}), 256'(0));
    checkOutput("reset_burst_address", 256'(burst_address), 256'(0));
    checkOutput("reset_burst_wdata", 256'(burst_wdata), 256'(0));
    checkOutput("reset_line_rdata", line_rdata, 256'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Aligned read with back-to-back beats.
    mem[32'h0000_1220] = {64'hD, 64'hC, 64'hB, 64'hA};
    resp_mode = 1;
    applyStimulus(1'b1, 1'b0, 32'h0000_1234, '0, 5);
    repeat (2) @(negedge clk);

    // Write with two idle cycles between beats.
    resp_mode = 2;
    applyStimulus(1'b0, 1'b1, 32'h0000_5000,
                  {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0);
    repeat (2) @(negedge clk);

    // Read and write together: write wins.
    resp_mode = 1;
    applyStimulus(1'b1, 1'b1, 32'h0000_6010, randLine(), 5);
    repeat (2) @(negedge clk);

    // Read, then write issued straight away, then read back the written line.
    applyStimulus(1'b1, 1'b0, 32'h0000_7040, '0, 5);
    tmp = randLine();
    applyStimulus(1'b0, 1'b1, 32'h0000_7040, tmp, 6);
    applyStimulus(1'b1, 1'b0, 32'h0000_705F, '0, 6);
    repeat (2) @(negedge clk);

    // Reset in the middle of a read after two beats.
    resp_mode    = 3;
    resp_limit   = 2;
    cur_addr     = 32'h0000_2000;
    cur_line     = randLine();
    cur_is_write = 1'b0;
    line_address = 32'h0000_2008;
    line_read    = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("stalled_burst_read", 256'(burst_read), 256'(1));
    abort_ok  = 1'b1;
    rst       = 1'b1;
    line_read = 1'b0;
    @(negedge clk);
    checkOutput("abort_burst_read", 256'(burst_read), 256'(0));
    checkOutput("abort_line_resp", 256'(line_resp), 256'(0));
    checkOutput("abort_line_rdata", line_rdata, 256'(0));
    rst       = 1'b0;
    last_read = '0;
    repeat (2) @(negedge clk);
    abort_ok  = 1'b0;
    resp_mode = 1;
    applyStimulus(1'b1, 1'b0, 32'h0000_2008, '0, 5);
    repeat (2) @(negedge clk);

    // Stray acknowledges while idle must not advance the beat count.
    stray_mode = 2;
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0000_3000, '0, 5);
    stray_mode = 0;
    repeat (2) @(negedge clk);

    // Randomized traffic over a small set of lines.
    resp_mode  = 0;
    stray_mode = 1;
    for (int t = 0; t < 40; t++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      a = 32'h0000_4000 + ($urandom_range(0, 7) << 5) + $urandom_range(0, 31);
      if (kind == 0) applyStimulus(1'b1, 1'b1, a, randLine(), 0);
      else if (kind < 5) applyStimulus(1'b0, 1'b1, a, randLine(), 0);
      else applyStimulus(1'b1, 1'b0, a, randLine(), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    stray_mode = 0;

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", 256'(sb_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
